bool_lut_sweeper: RTL and testbench

Parametrised, registered successor to the fixed two-input NAND function blocks. Evaluates a programmable N-input boolean function stored as a truth-table mask. Two modes: single evaluation of a supplied input vector, or an automatic sweep of all 2^N_IN input combinations in index order. Results go out on a valid/ready stream, and a sweep also reports a ones count. Sits between the stimulus/config logic and result consumers, such as a display or checker, and replaces hand-written truth-table benches.

---
 rtl/bool_lut_sweeper.sv | 99 +++++++++
 tb/tb_bool_lut_sweeper.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bool_lut_sweeper.sv
// Programmable N-input boolean function (truth-table mask): single evaluation or full in-order sweep.
// Latency: result valid one cycle after an accepted start; one result per cycle while out_ready is high.
// Backpressure: out_valid/out_vec/out_s held stable while out_ready is low; start/cfg_we ignored when busy.
module bool_lut_sweeper #(
  parameter int                      N_IN       = 2,
  parameter logic [(1<<N_IN)-1:0]    RESET_MASK = 4'hD
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cfg_we,
  input  logic [(1<<N_IN)-1:0]  cfg_mask,
  input  logic                  start,
  input  logic                  mode,
  input  logic [N_IN-1:0]       in_vec,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [N_IN-1:0]       out_vec,
  output logic                  out_s,
  output logic                  busy,
  output logic                  done,
  output logic [N_IN:0]         ones_count
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EMIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [N_IN-1:0] LAST_IDX = '1;

  state_t                 state;
  logic [(1<<N_IN)-1:0]   mask;
  logic [N_IN-1:0]        index;
  logic                   sweep;
  logic                   hs;

  assign hs      = out_valid & out_ready;
  assign out_vec = index;
  assign busy    = (state != S_IDLE);

  // Function value looked up from registered index and mask; forced low when no result is presented.
  assign out_s = out_valid & mask[index];

  // Control FSM: mask config in IDLE, result emission with handshake, one-cycle done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      mask       <= RESET_MASK;
      index      <= '0;
      sweep      <= 1'b0;
      out_valid  <= 1'b0;
      done       <= 1'b0;
      ones_count <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          // A mask write in the start cycle lands before the first lookup.
          if (cfg_we) begin
            mask <= cfg_mask;
          end
          if (start) begin
            sweep      <= mode;
            index      <= mode ? '0 : in_vec;
            ones_count <= '0;
            out_valid  <= 1'b1;
            state      <= S_EMIT;
          end
        end
        S_EMIT: begin
          if (hs) begin
            if (sweep) begin
              ones_count <= ones_count + (N_IN+1)'(out_s);
            end
            // Sweep stops at the last index rather than wrapping into a second pass.
            if (sweep && (index != LAST_IDX)) begin
              index <= index + 1'b1;
            end else begin
              out_valid <= 1'b0;
              done      <= 1'b1;
              state     <= S_DONE;
            end
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          out_valid <= 1'b0;
          done      <= 1'b0;
          state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bool_lut_sweeper.sv
// Self-checking bench for bool_lut_sweeper: table vectors, directed corner sequences, randomized ops vs model.
// Two instances: N_IN=2 with default mask, N_IN=3 for the XOR3 sweep.
// Inputs driven 1 time unit after the rising edge, outputs sampled on the falling edge.
module tb_bool_lut_sweeper;

  logic clk;
  logic rst_n;

  // N_IN = 2 instance
  logic       cfg_we;
  logic [3:0] cfg_mask;
  logic       start;
  logic       mode;
  logic [1:0] in_vec;
  logic       out_valid;
  logic       out_ready;
  logic [1:0] out_vec;
  logic       out_s;
  logic       busy;
  logic       done;
  logic [2:0] ones_count;

  // N_IN = 3 instance
  logic       cfg_we3;
  logic [7:0] cfg_mask3;
  logic       start3;
  logic       mode3;
  logic [2:0] in_vec3;
  logic       out_valid3;
  logic       out_ready3;
  logic [2:0] out_vec3;
  logic       out_s3;
  logic       busy3;
  logic       done3;
  logic [3:0] ones_count3;

  int tests;
  int fails;

  logic [1:0] got_vec[$];
  logic       got_s[$];
  int         first_valid_cyc;
  int         done_cyc;
  int         last_hs_cyc;
  logic [3:0] cur_mask;

  typedef struct {
    logic [1:0] v;
    logic       exp_s;
  } vec_t;

  vec_t tbl[4];

  bool_lut_sweeper #(.N_IN(2), .RESET_MASK(4'hD)) dut2 (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_mask(cfg_mask),
    .start(start), .mode(mode), .in_vec(in_vec), .out_valid(out_valid),
    .out_ready(out_ready), .out_vec(out_vec), .out_s(out_s), .busy(busy),
    .done(done), .ones_count(ones_count)
  );

  bool_lut_sweeper #(.N_IN(3), .RESET_MASK(8'h00)) dut3 (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we3), .cfg_mask(cfg_mask3),
    .start(start3), .mode(mode3), .in_vec(in_vec3), .out_valid(out_valid3),
    .out_ready(out_ready3), .out_vec(out_vec3), .out_s(out_s3), .busy(busy3),
    .done(done3), .ones_count(ones_count3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input int act, input int exp_v);
    tests++;
    if (act != exp_v) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp_v);
    end
  endtask

  function automatic logic ready_at(input int rp, input int c);
    case (rp)
      0:       return 1'b1;
      1:       return (c % 2) == 1;
      2:       return c > 3;
      default: return 1'($urandom % 2);
    endcase
  endfunction

  // One operation on the N_IN=2 instance; records accepted results and timing.
  // wr: write wm together with start. inj: cycle at which a stray start + cfg_we 4'hF is issued.
  task automatic do_op(input bit m, input logic [1:0] v, input int rp,
                       input bit wr, input logic [3:0] wm, input int inj);
    bit         pv;
    logic [1:0] pvec;
    logic       ps;
    got_vec.delete();
    got_s.delete();
    first_valid_cyc = -1;
    done_cyc        = -1;
    last_hs_cyc     = -1;
    pv   = 1'b0;
    pvec = '0;
    ps   = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; mode = m; in_vec = v; cfg_we = wr; cfg_mask = wm;
    out_ready = 1'b0;
    @(posedge clk); #1;
    start = 1'b0; cfg_we = 1'b0;
    mode = 1'($urandom); in_vec = 2'($urandom);
    out_ready = ready_at(rp, 1);
    for (int cyc = 1; cyc < 200; cyc++) begin
      @(negedge clk);
      if (pv) begin
        check("hold_valid", out_valid, 1);
        check("hold_vec", out_vec, pvec);
        check("hold_s", out_s, ps);
      end
      if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (out_valid) check("busy_emit", busy, 1);
      pv   = out_valid && !out_ready;
      pvec = out_vec;
      ps   = out_s;
      if (out_valid && out_ready) begin
        got_vec.push_back(out_vec);
        got_s.push_back(out_s);
        last_hs_cyc = cyc;
      end
      if (done) begin
        done_cyc = cyc;
        check("done_no_valid", out_valid, 0);
        start = 1'b0; cfg_we = 1'b0;
        break;
      end
      @(posedge clk); #1;
      out_ready = ready_at(rp, cyc + 1);
      start     = (cyc == inj);
      cfg_we    = (cyc == inj);
      cfg_mask  = 4'hF;
    end
    if (done_cyc < 0) begin
      check("done_timeout", 0, 1);
      start = 1'b0; cfg_we = 1'b0;
    end
    @(negedge clk);
    check("done_one_cycle", done, 0);
    check("idle_busy", busy, 0);
  endtask

  // Compare the recorded operation against the truth-table model.
  task automatic verify(input string nm, input bit m, input logic [1:0] v, input logic [3:0] mk);
    int n;
    int ones;
    int idx;
    int e;
    n    = m ? 4 : 1;
    ones = 0;
    check({nm, "_n_results"}, got_s.size(), n);
    for (int i = 0; i < n && i < got_s.size(); i++) begin
      idx = m ? i : int'(v);
      e   = (int'(mk) >> idx) & 1;
      if (m) ones += e;
      check({nm, "_vec"}, got_vec[i], idx);
      check({nm, "_s"}, got_s[i], e);
    end
    check({nm, "_ones"}, ones_count, ones);
    check({nm, "_first_valid"}, first_valid_cyc, 1);
    check({nm, "_done_after_last"}, done_cyc, last_hs_cyc + 1);
  endtask

  initial begin
    int n3;
    int d3;
    int ones3;
    tests = 0; fails = 0;
    tbl[0] = '{v: 2'b00, exp_s: 1'b1};
    tbl[1] = '{v: 2'b01, exp_s: 1'b0};
    tbl[2] = '{v: 2'b10, exp_s: 1'b1};
    tbl[3] = '{v: 2'b11, exp_s: 1'b1};

    rst_n = 1'b0;
    cfg_we = 0; cfg_mask = 0; start = 0; mode = 0; in_vec = 0; out_ready = 0;
    cfg_we3 = 0; cfg_mask3 = 0; start3 = 0; mode3 = 0; in_vec3 = 0; out_ready3 = 0;
    cur_mask = 4'hD;
    #23;
    check("rst_valid", out_valid, 0);
    check("rst_vec", out_vec, 0);
    check("rst_s", out_s, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ones", ones_count, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Reset-default sweep, ready held high: results t+1..t+4, done t+5, ones 3.
    do_op(1, 2'b00, 0, 0, 4'h0, 0);
    verify("sweep_default", 1, 2'b00, cur_mask);
    check("sweep_default_done_cyc", done_cyc, 5);

    // Table of single evaluations against the default mask.
    for (int i = 0; i < 4; i++) begin
      do_op(0, tbl[i].v, 0, 0, 4'h0, 0);
      check("tbl_n", got_s.size(), 1);
      if (got_s.size() > 0) begin
        check("tbl_vec", got_vec[0], tbl[i].v);
        check("tbl_s", got_s[0], tbl[i].exp_s);
      end
      check("tbl_ones", ones_count, 0);
    end

    // Single mode, in_vec 01, ready low for 3 cycles.
    do_op(0, 2'b01, 2, 0, 4'h0, 0);
    verify("single_stall", 0, 2'b01, cur_mask);
    check("single_stall_accept_cyc", last_hs_cyc, 4);

    // Sweep with alternating ready.
    do_op(1, 2'b00, 1, 0, 4'h0, 0);
    verify("sweep_toggle", 1, 2'b00, cur_mask);

    // Mask 8 written with start; stray start + cfg_we 4'hF mid-sweep must be ignored.
    do_op(1, 2'b00, 0, 1, 4'h8, 2);
    cur_mask = 4'h8;
    verify("sweep_and", 1, 2'b00, cur_mask);
    check("sweep_and_ones", ones_count, 1);
    do_op(1, 2'b00, 0, 0, 4'h0, 0);
    verify("sweep_and_kept", 1, 2'b00, cur_mask);

    // Reset mid-sweep after the second result: async clear, mask reverts.
    @(posedge clk); #1;
    start = 1'b1; mode = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3;
    check("mid_valid_before_rst", out_valid, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_vec", out_vec, 0);
    check("mid_rst_s", out_s, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_ones", ones_count, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    cur_mask = 4'hD;
    do_op(1, 2'b00, 0, 0, 4'h0, 0);
    verify("sweep_after_rst", 1, 2'b00, cur_mask);

    // Randomized operations, mask written with start each time.
    for (int k = 0; k < 24; k++) begin
      bit         rm;
      logic [1:0] rv;
      logic [3:0] rmask;
      rm    = 1'($urandom);
      rv    = 2'($urandom);
      rmask = 4'($urandom);
      do_op(rm, rv, 3, 1, rmask, 0);
      cur_mask = rmask;
      verify("rand", rm, rv, cur_mask);
    end

    // N_IN = 3, XOR3 sweep.
    @(posedge clk); #1;
    cfg_we3 = 1'b1; cfg_mask3 = 8'h96;
    @(posedge clk); #1;
    cfg_we3 = 1'b0; start3 = 1'b1; mode3 = 1'b1; out_ready3 = 1'b1;
    @(posedge clk); #1;
    start3 = 1'b0;
    n3 = 0; d3 = -1; ones3 = 0;
    for (int cyc = 1; cyc < 16; cyc++) begin
      @(negedge clk);
      if (out_valid3) begin
        check("x3_vec", out_vec3, n3 % 8);
        check("x3_s", out_s3, (8'h96 >> (n3 % 8)) & 1);
        ones3 += (8'h96 >> (n3 % 8)) & 1;
        n3++;
      end
      if (done3 && d3 < 0) d3 = cyc;
    end
    check("x3_n_results", n3, 8);
    check("x3_done_cyc", d3, 9);
    check("x3_ones", ones_count3, 4);
    check("x3_ones_model", ones3, 4);
    check("x3_idle", busy3, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
